lcd_write_arbiter: RTL and testbench

//  Shares the single SPI LCD writer (9-bit word: bit8 = D/C, bits7:0 = byte; en_write pulse in, wr_done pulse out)

---
 rtl/lcd_write_arbiter_if.sv | 26 ++
 rtl/lcd_write_arbiter.sv | 139 +++++++++++++
 tb/tb_lcd_write_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_write_arbiter_if.sv
// Bus between the LCD write arbiter and its environment: the requester
// side (req / data / strobe / done / grant) plus the single SPI LCD writer
// (data / en_write / wr_done).  The arbiter is the slave; the requesters
// together with the writer form the master side.
interface lcd_write_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [9*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_en_write;
  logic [NUM_REQ-1:0]   req_done;
  logic [NUM_REQ-1:0]   gnt;
  logic [8:0]           data;
  logic                 en_write;
  logic                 wr_done;

  modport master (
    output req, req_data, req_en_write, wr_done,
    input  req_done, gnt, data, en_write
  );

  modport slave (
    input  req, req_data, req_en_write, wr_done,
    output req_done, gnt, data, en_write
  );
endinterface

// File: rtl/lcd_write_arbiter.sv
// Shares one SPI LCD writer (9-bit word, bit8 = D/C) between NUM_REQ
// requesters.  Port 0 (panel init) is the only eligible port until
// init_done; afterwards grants rotate round-robin.  A grant is held for a
// whole burst until the owner drops req.  A wr_done watchdog keeps a stuck
// writer from hanging the owner, and sticky flags record protocol misuse.
module lcd_write_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                init_done,
  lcd_write_arbiter_if.slave  bus,
  output logic                timeout_err,
  output logic                proto_err
);

  localparam int                 IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0]   PTR_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    BUSY
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;        // last winner; equals the owner while granted
  logic [NUM_REQ-1:0] gnt_q;
  logic [8:0]         data_q;
  logic               en_write_q;
  logic [CNT_W-1:0]   wd_cnt;

  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  int                 cand;
  logic [8:0]         owner_word;
  logic               owner_req;
  logic               owner_strobe;
  logic               stray_strobe;
  logic               busy_end;

  // Round-robin search upward from ptr+1; the nearest set bit wins.
  // NOTE: every always_comb output gets a default before any branch or loop,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    eligible  = bus.req & (init_done ? {NUM_REQ{1'b1}} : NUM_REQ'(1));
    win_idx   = ptr;
    win_found = 1'b0;
    cand      = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (eligible[cand]) begin
        win_idx   = IDX_W'(cand);
        win_found = 1'b1;
      end
    end
  end

  // Owner-side view of the request bus and the completion condition.
  always_comb begin
    owner_word   = bus.req_data[9*ptr +: 9];
    owner_req    = bus.req[ptr];
    owner_strobe = bus.req_en_write[ptr];
    stray_strobe = |(bus.req_en_write & ~gnt_q);
    busy_end     = (state == BUSY) && (bus.wr_done || (wd_cnt == WD_LAST));
  end

  // Completion is routed straight through so the owner sees it in the
  // same cycle as wr_done (or the watchdog expiry).
  assign bus.req_done = gnt_q & {NUM_REQ{busy_end}};
  assign bus.gnt      = gnt_q;
  assign bus.data     = data_q;
  assign bus.en_write = en_write_q;

  // Arbitration FSM, writer strobe, watchdog and sticky error flags.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      ptr         <= PTR_RST;
      gnt_q       <= '0;
      data_q      <= '0;
      en_write_q  <= 1'b0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      en_write_q <= 1'b0;

      // Strobes from non-owners, strobes while a word is in flight and
      // completions nobody is waiting for are dropped and flagged.
      if (stray_strobe ||
          ((state == BUSY) && owner_strobe) ||
          ((state != BUSY) && bus.wr_done)) begin
        proto_err <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (win_found) begin
            gnt_q <= NUM_REQ'(1) << win_idx;
            ptr   <= win_idx;
            state <= OWNED;
          end
        end
        OWNED: begin
          // A strobe is honoured even if req drops in the same cycle.
          if (owner_strobe) begin
            data_q     <= owner_word;
            en_write_q <= 1'b1;
            wd_cnt     <= '0;
            state      <= BUSY;
          end else if (!owner_req) begin
            gnt_q <= '0;
            state <= IDLE;
          end
        end
        BUSY: begin
          // wr_done wins over a simultaneous watchdog expiry.
          if (bus.wr_done) begin
            state <= OWNED;
          end else if (wd_cnt == WD_LAST) begin
            timeout_err <= 1'b1;
            state       <= OWNED;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: init lock, word path, round-robin
// rotation, watchdog, stray/overlapping strobes and async reset.
module tb_lcd_write_arbiter;

  localparam int NUM_REQ     = 3;
  localparam int TIMEOUT_CYC = 16;
  localparam int CNT_W       = 5;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic init_done = 1'b0;
  logic timeout_err;
  logic proto_err;

  int n_checks = 0;
  int n_errors = 0;

  lcd_write_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  lcd_write_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .init_done   (init_done),
    .bus         (bus),
    .timeout_err (timeout_err),
    .proto_err   (proto_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return on the falling edge, away from sampling.
  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  // One word by the current owner, completed by wr_done in BUSY cycle 3.
  task automatic do_word(input int port, input logic [8:0] word);
    bus.req_data[9*port +: 9] = word;
    bus.req_en_write          = 3'b001 << port;
    tick();
    check("word_en_write", 32'(bus.en_write), 32'd1);
    check("word_data", 32'(bus.data), 32'(word));
    bus.req_en_write = '0;
    tick();
    check("word_en_write_drop", 32'(bus.en_write), 32'd0);
    tick();
    bus.wr_done = 1'b1;
    #1;
    check("word_req_done", 32'(bus.req_done), 32'(3'b001 << port));
    tick();
    bus.wr_done = 1'b0;
    #1;
    check("word_req_done_drop", 32'(bus.req_done), 32'd0);
  endtask

  initial begin
    int order [6] = '{0, 1, 2, 0, 1, 2};
    logic [8:0] w;

    bus.req          = '0;
    bus.req_data     = '0;
    bus.req_en_write = '0;
    bus.wr_done      = 1'b0;

    // Reset state
    #2;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_data", 32'(bus.data), 32'd0);
    check("rst_en_write", 32'(bus.en_write), 32'd0);
    check("rst_req_done", 32'(bus.req_done), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // T1 init lock
    bus.req = 3'b110;
    tick();
    check("t1_locked_a", 32'(bus.gnt), 32'd0);
    tick();
    check("t1_locked_b", 32'(bus.gnt), 32'd0);
    bus.req = 3'b111;
    tick();
    check("t1_init_gnt", 32'(bus.gnt), 32'(3'b001));
    bus.req   = 3'b110;
    init_done = 1'b1;
    tick();
    check("t1_release0", 32'(bus.gnt), 32'd0);
    tick();
    check("t1_gnt1", 32'(bus.gnt), 32'(3'b010));
    bus.req = 3'b100;
    tick();
    check("t1_release1", 32'(bus.gnt), 32'd0);
    tick();
    check("t1_gnt2", 32'(bus.gnt), 32'(3'b100));
    bus.req = 3'b000;
    tick();
    check("t1_release2", 32'(bus.gnt), 32'd0);

    // T2 word path, owner 1, wr_done in BUSY cycle 12
    bus.req = 3'b010;
    tick();
    check("t2_gnt", 32'(bus.gnt), 32'(3'b010));
    bus.req_data[17:9] = 9'h12C;
    bus.req_en_write   = 3'b010;
    tick();
    check("t2_en_write", 32'(bus.en_write), 32'd1);
    check("t2_data", 32'(bus.data), 32'h12C);
    bus.req_en_write = '0;
    for (int c = 2; c <= 12; c++) begin
      tick();
      check("t2_wait_done", 32'(bus.req_done), 32'd0);
    end
    check("t2_en_write_single", 32'(bus.en_write), 32'd0);
    check("t2_data_hold", 32'(bus.data), 32'h12C);
    bus.wr_done = 1'b1;
    #1;
    check("t2_req_done", 32'(bus.req_done), 32'(3'b010));
    tick();
    bus.wr_done = 1'b0;
    #1;
    check("t2_req_done_once", 32'(bus.req_done), 32'd0);
    check("t2_proto_clean", 32'(proto_err), 32'd0);
    bus.req = 3'b000;
    tick();
    check("t2_release", 32'(bus.gnt), 32'd0);

    // Move the pointer to port 2 so the next rotation starts at port 0
    bus.req = 3'b100;
    tick();
    check("pre_t3_gnt2", 32'(bus.gnt), 32'(3'b100));
    bus.req = 3'b000;
    tick();
    check("pre_t3_release", 32'(bus.gnt), 32'd0);

    // T3 round-robin: 2 words per owner, one idle grant cycle between owners
    bus.req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t3_gnt", 32'(bus.gnt), 32'(3'b001 << order[i]));
      for (int j = 0; j < 2; j++) begin
        w = 9'(9'h100 + 16 * i + j);
        do_word(order[i], w);
      end
      bus.req[order[i]] = 1'b0;
      tick();
      check("t3_gap", 32'(bus.gnt), 32'd0);
      bus.req = 3'b111;
    end
    check("t3_proto_clean", 32'(proto_err), 32'd0);

    // T4 watchdog, owner 0, wr_done never returned
    bus.req = 3'b001;
    tick();
    check("t4_gnt", 32'(bus.gnt), 32'(3'b001));
    bus.req_data[8:0] = 9'h0A5;
    bus.req_en_write  = 3'b001;
    tick();
    check("t4_en_write", 32'(bus.en_write), 32'd1);
    check("t4_data", 32'(bus.data), 32'h0A5);
    bus.req_en_write = '0;
    for (int c = 2; c <= 15; c++) begin
      tick();
      check("t4_no_done", 32'(bus.req_done), 32'd0);
    end
    tick();
    check("t4_timeout_pulse", 32'(bus.req_done), 32'(3'b001));
    check("t4_err_not_yet", 32'(timeout_err), 32'd0);
    tick();
    check("t4_pulse_drop", 32'(bus.req_done), 32'd0);
    check("t4_timeout_err", 32'(timeout_err), 32'd1);
    check("t4_still_owned", 32'(bus.gnt), 32'(3'b001));
    check("t4_proto_clean", 32'(proto_err), 32'd0);
    bus.wr_done = 1'b1;
    #1;
    check("t4_late_done_ignored", 32'(bus.req_done), 32'd0);
    tick();
    bus.wr_done = 1'b0;
    check("t4_late_done_proto", 32'(proto_err), 32'd1);
    check("t4_gnt_kept", 32'(bus.gnt), 32'(3'b001));
    do_word(0, 9'h033);
    bus.req = 3'b000;
    tick();
    check("t4_release", 32'(bus.gnt), 32'd0);

    // T6 async reset while port 1 is BUSY
    bus.req = 3'b010;
    tick();
    check("t6_gnt1", 32'(bus.gnt), 32'(3'b010));
    bus.req_data[17:9] = 9'h1C3;
    bus.req_en_write   = 3'b010;
    tick();
    check("t6_en_write", 32'(bus.en_write), 32'd1);
    bus.req_en_write = '0;
    tick();
    sys_rst_n = 1'b0;
    #1;
    check("t6_gnt", 32'(bus.gnt), 32'd0);
    check("t6_data", 32'(bus.data), 32'd0);
    check("t6_en_write_rst", 32'(bus.en_write), 32'd0);
    check("t6_timeout_err", 32'(timeout_err), 32'd0);
    check("t6_proto_err", 32'(proto_err), 32'd0);
    bus.wr_done = 1'b1;
    #1;
    check("t6_no_req_done", 32'(bus.req_done), 32'd0);
    bus.wr_done = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    bus.req   = 3'b011;
    tick();
    check("t6_port0_first", 32'(bus.gnt), 32'(3'b001));
    bus.req = 3'b000;
    tick();
    check("t6_release", 32'(bus.gnt), 32'd0);

    // T5 stray strobe from ungranted port 2
    check("t5_proto_clean", 32'(proto_err), 32'd0);
    bus.req = 3'b001;
    tick();
    check("t5_gnt0", 32'(bus.gnt), 32'(3'b001));
    bus.req_data[26:18] = 9'h1FF;
    bus.req_en_write    = 3'b100;
    tick();
    check("t5_stray_no_write", 32'(bus.en_write), 32'd0);
    check("t5_stray_no_data", 32'(bus.data), 32'd0);
    check("t5_stray_proto", 32'(proto_err), 32'd1);
    bus.req_en_write = '0;

    // T5 overlapping strobe: clear the sticky flag first
    sys_rst_n = 1'b0;
    #1;
    check("t5_proto_cleared", 32'(proto_err), 32'd0);
    #1;
    sys_rst_n = 1'b1;
    tick();
    check("t5_regrant0", 32'(bus.gnt), 32'(3'b001));
    bus.req_data[8:0] = 9'h055;
    bus.req_en_write  = 3'b001;
    tick();
    check("t5_first_write", 32'(bus.en_write), 32'd1);
    check("t5_first_data", 32'(bus.data), 32'h055);
    bus.req_data[8:0] = 9'h0AA;
    tick();
    check("t5_overlap_no_write", 32'(bus.en_write), 32'd0);
    check("t5_overlap_data", 32'(bus.data), 32'h055);
    check("t5_overlap_proto", 32'(proto_err), 32'd1);
    bus.req_en_write = '0;
    tick();
    check("t5_single_write", 32'(bus.en_write), 32'd0);
    bus.wr_done = 1'b1;
    #1;
    check("t5_req_done", 32'(bus.req_done), 32'(3'b001));
    tick();
    bus.wr_done = 1'b0;
    #1;
    check("t5_req_done_once", 32'(bus.req_done), 32'd0);
    bus.req = 3'b000;
    tick();
    check("t5_release", 32'(bus.gnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
